// File: rtl/ccip_host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ccip_host_mem_responder
// Description : Host/FIU-side CCI-P responder. Services single-line c0 reads
//               and c1 writes from an internal line memory, returning
//               fixed-latency responses that echo the request mdata. A
//               backdoor port preloads and inspects memory.
// Revision    : 1.0 - initial release
// ============================================================================
module ccip_host_mem_responder #(
  parameter int ADDR_W         = 42,
  parameter int DATA_W         = 512,
  parameter int MDATA_W        = 16,
  parameter int DEPTH_LOG2     = 10,
  parameter int RD_LATENCY     = 4,
  parameter int WR_LATENCY     = 2,
  parameter int ALMFULL_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  c0_req_valid,
  input  logic [ADDR_W-1:0]     c0_req_addr,
  input  logic [MDATA_W-1:0]    c0_req_mdata,
  input  logic                  c1_req_valid,
  input  logic [ADDR_W-1:0]     c1_req_addr,
  input  logic [DATA_W-1:0]     c1_req_data,
  input  logic [MDATA_W-1:0]    c1_req_mdata,
  output logic                  c0_alm_full,
  output logic                  c1_alm_full,
  output logic                  c0_rsp_valid,
  output logic [DATA_W-1:0]     c0_rsp_data,
  output logic [MDATA_W-1:0]    c0_rsp_mdata,
  output logic                  c1_rsp_valid,
  output logic [MDATA_W-1:0]    c1_rsp_mdata,
  input  logic                  bd_wr_en,
  input  logic                  bd_rd_en,
  input  logic [DEPTH_LOG2-1:0] bd_addr,
  input  logic [DATA_W-1:0]     bd_wr_data,
  output logic [DATA_W-1:0]     bd_rd_data,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // In-flight count never exceeds the latency (max 16), so 6 bits is ample.
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] c_alm_thresh = CNT_W'(ALMFULL_THRESH);

  logic [DATA_W-1:0]     mem_q [DEPTH];

  logic                  w_c0_acc;
  logic                  w_c1_acc;
  logic                  w_c0_oor;
  logic                  w_c1_oor;
  logic [DEPTH_LOG2-1:0] w_c0_idx;
  logic [DEPTH_LOG2-1:0] w_c1_idx;
  logic [DATA_W-1:0]     w_c0_rd_data;

  logic                  rd_vld_q   [RD_LATENCY];
  logic [MDATA_W-1:0]    rd_mdata_q [RD_LATENCY];
  logic [DATA_W-1:0]     rd_data_q  [RD_LATENCY];
  logic                  wr_vld_q   [WR_LATENCY];
  logic [MDATA_W-1:0]    wr_mdata_q [WR_LATENCY];

  logic [CNT_W-1:0]      rd_infl_q, rd_infl_d;
  logic [CNT_W-1:0]      wr_infl_q, wr_infl_d;
  logic                  c0_alm_q, c1_alm_q;
  logic [31:0]           rd_cnt_q, wr_cnt_q;
  logic [DATA_W-1:0]     bd_rd_data_q;

  // Requests are accepted unconditionally outside reset; alm_full is advisory.
  assign w_c0_acc = c0_req_valid && reset_n;
  assign w_c1_acc = c1_req_valid && reset_n;

  // Any address bit above the line index makes the access out of range.
  assign w_c0_oor = |c0_req_addr[ADDR_W-1:DEPTH_LOG2];
  assign w_c1_oor = |c1_req_addr[ADDR_W-1:DEPTH_LOG2];
  assign w_c0_idx = c0_req_addr[DEPTH_LOG2-1:0];
  assign w_c1_idx = c1_req_addr[DEPTH_LOG2-1:0];

  // Read samples memory combinationally in the acceptance cycle, so a
  // same-cycle write to the same line is not yet visible (old data returned).
  assign w_c0_rd_data = w_c0_oor ? '0 : mem_q[w_c0_idx];

  // Line memory (not reset); backdoor is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (w_c1_acc && !w_c1_oor) mem_q[w_c1_idx] <= c1_req_data;
    if (bd_wr_en)              mem_q[bd_addr]  <= bd_wr_data;
  end

  // Read-response latency pipeline; reset flushes requests in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_vld_q[i]   <= 1'b0;
        rd_mdata_q[i] <= '0;
        rd_data_q[i]  <= '0;
      end
    end else begin
      rd_vld_q[0]   <= w_c0_acc;
      rd_mdata_q[0] <= w_c0_acc ? c0_req_mdata : '0;
      rd_data_q[0]  <= w_c0_acc ? w_c0_rd_data : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i]   <= rd_vld_q[i-1];
        rd_mdata_q[i] <= rd_mdata_q[i-1];
        rd_data_q[i]  <= rd_data_q[i-1];
      end
    end
  end

  // Write-response latency pipeline; reset flushes requests in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < WR_LATENCY; i++) begin
        wr_vld_q[i]   <= 1'b0;
        wr_mdata_q[i] <= '0;
      end
    end else begin
      wr_vld_q[0]   <= w_c1_acc;
      wr_mdata_q[0] <= w_c1_acc ? c1_req_mdata : '0;
      for (int i = 1; i < WR_LATENCY; i++) begin
        wr_vld_q[i]   <= wr_vld_q[i-1];
        wr_mdata_q[i] <= wr_mdata_q[i-1];
      end
    end
  end

  assign c0_rsp_valid = rd_vld_q[RD_LATENCY-1];
  assign c0_rsp_data  = rd_data_q[RD_LATENCY-1];
  assign c0_rsp_mdata = rd_mdata_q[RD_LATENCY-1];
  assign c1_rsp_valid = wr_vld_q[WR_LATENCY-1];
  assign c1_rsp_mdata = wr_mdata_q[WR_LATENCY-1];

  // Next in-flight counts: +1 on accept, -1 on response, unchanged on both.
  always_comb begin
    rd_infl_d = rd_infl_q;
    wr_infl_d = wr_infl_q;
    case ({w_c0_acc, c0_rsp_valid})
      2'b10:   rd_infl_d = rd_infl_q + CNT_W'(1);
      2'b01:   rd_infl_d = rd_infl_q - CNT_W'(1);
      default: rd_infl_d = rd_infl_q;
    endcase
    case ({w_c1_acc, c1_rsp_valid})
      2'b10:   wr_infl_d = wr_infl_q + CNT_W'(1);
      2'b01:   wr_infl_d = wr_infl_q - CNT_W'(1);
      default: wr_infl_d = wr_infl_q;
    endcase
  end

  // In-flight counters, registered almost-full flags and request counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_infl_q <= '0;
      wr_infl_q <= '0;
      c0_alm_q  <= 1'b0;
      c1_alm_q  <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      rd_infl_q <= rd_infl_d;
      wr_infl_q <= wr_infl_d;
      c0_alm_q  <= (rd_infl_d >= c_alm_thresh);
      c1_alm_q  <= (wr_infl_d >= c_alm_thresh);
      if (w_c0_acc) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (w_c1_acc) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign c0_alm_full = c0_alm_q;
  assign c1_alm_full = c1_alm_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;

  // Backdoor read register; sees pre-write data on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (!reset_n)      bd_rd_data_q <= '0;
    else if (bd_rd_en) bd_rd_data_q <= mem_q[bd_addr];
  end

  assign bd_rd_data = bd_rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ccip_host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccip_host_mem_responder
// Description : Self-checking bench for ccip_host_mem_responder. Expected
//               responses are queued at issue time and matched (data, mdata,
//               arrival cycle) when the DUT returns them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccip_host_mem_responder;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         c0_req_valid, c1_req_valid;
  logic [41:0]  c0_req_addr, c1_req_addr;
  logic [15:0]  c0_req_mdata, c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         c0_alm_full, c1_alm_full;
  logic         c0_rsp_valid, c1_rsp_valid;
  logic [511:0] c0_rsp_data;
  logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
  logic         bd_wr_en, bd_rd_en;
  logic [9:0]   bd_addr;
  logic [511:0] bd_wr_data, bd_rd_data;
  logic [31:0]  rd_count, wr_count;

  typedef struct {
    int           cyc;
    logic [15:0]  mdata;
    logic [511:0] data;
  } exp_t;

  exp_t rdq[$];
  exp_t wrq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_rd = 0;
  int   exp_wr = 0;

  ccip_host_mem_responder #(
    .ADDR_W(42), .DATA_W(512), .MDATA_W(16), .DEPTH_LOG2(10),
    .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT), .ALMFULL_THRESH(3)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data),
    .c1_req_mdata(c1_req_mdata),
    .c0_alm_full(c0_alm_full), .c1_alm_full(c1_alm_full),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_data(c0_rsp_data), .c0_rsp_mdata(c0_rsp_mdata),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .bd_wr_en(bd_wr_en), .bd_rd_en(bd_rd_en), .bd_addr(bd_addr),
    .bd_wr_data(bd_wr_data), .bd_rd_data(bd_rd_data),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: match each response against the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && c0_rsp_valid) begin
      n_checks++;
      if (rdq.size() == 0) begin
        n_fail++;
        $display("FAIL c0_rsp_unexpected: got mdata %h at cycle %0d, required no response", c0_rsp_mdata, cyc);
      end else begin
        e = rdq.pop_front();
        if (c0_rsp_data !== e.data || c0_rsp_mdata !== e.mdata || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL c0_rsp: got cyc %0d mdata %h data %h, required cyc %0d mdata %h data %h",
                   cyc, c0_rsp_mdata, c0_rsp_data, e.cyc, e.mdata, e.data);
        end
      end
    end
    if (reset_n && c1_rsp_valid) begin
      n_checks++;
      if (wrq.size() == 0) begin
        n_fail++;
        $display("FAIL c1_rsp_unexpected: got mdata %h at cycle %0d, required no response", c1_rsp_mdata, cyc);
      end else begin
        e = wrq.pop_front();
        if (c1_rsp_mdata !== e.mdata || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL c1_rsp: got cyc %0d mdata %h, required cyc %0d mdata %h",
                   cyc, c1_rsp_mdata, e.cyc, e.mdata);
        end
      end
    end
  end

  function automatic logic [511:0] pat(input int i);
    logic [31:0] w;
    w = 32'h1000_0000 + 32'(i);
    return {16{w}};
  endfunction

  // Advance one cycle; strobes are single-cycle unless re-driven.
  task automatic tick();
    @(posedge clk);
    #1;
    c0_req_valid = 1'b0;
    c1_req_valid = 1'b0;
    bd_wr_en     = 1'b0;
    bd_rd_en     = 1'b0;
  endtask

  task automatic issue_rd(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d);
    exp_t e;
    c0_req_valid = 1'b1; c0_req_addr = a; c0_req_mdata = m;
    e.cyc = cyc + RD_LAT; e.mdata = m; e.data = d;
    rdq.push_back(e);
    exp_rd++;
  endtask

  task automatic issue_wr(input logic [41:0] a, input logic [511:0] d, input logic [15:0] m);
    exp_t e;
    c1_req_valid = 1'b1; c1_req_addr = a; c1_req_data = d; c1_req_mdata = m;
    e.cyc = cyc + WR_LAT; e.mdata = m; e.data = '0;
    wrq.push_back(e);
    exp_wr++;
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [511:0] d);
    bd_wr_en = 1'b1; bd_addr = a; bd_wr_data = d;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((rdq.size() != 0 || wrq.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (rdq.size() != 0 || wrq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d rd / %0d wr responses outstanding, required 0", name, rdq.size(), wrq.size());
      rdq.delete();
      wrq.delete();
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick(); tick();
    n_checks += 10;
    if (c0_alm_full !== 1'b0)  begin n_fail++; $display("FAIL rst_c0_alm: got %b, required 0", c0_alm_full); end
    if (c1_alm_full !== 1'b0)  begin n_fail++; $display("FAIL rst_c1_alm: got %b, required 0", c1_alm_full); end
    if (c0_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_c0_vld: got %b, required 0", c0_rsp_valid); end
    if (c1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_c1_vld: got %b, required 0", c1_rsp_valid); end
    if (c0_rsp_data !== '0)    begin n_fail++; $display("FAIL rst_c0_data: got %h, required 0", c0_rsp_data); end
    if (c0_rsp_mdata !== '0)   begin n_fail++; $display("FAIL rst_c0_mdata: got %h, required 0", c0_rsp_mdata); end
    if (c1_rsp_mdata !== '0)   begin n_fail++; $display("FAIL rst_c1_mdata: got %h, required 0", c1_rsp_mdata); end
    if (bd_rd_data !== '0)     begin n_fail++; $display("FAIL rst_bd_rd: got %h, required 0", bd_rd_data); end
    if (rd_count !== 32'd0)    begin n_fail++; $display("FAIL rst_rd_count: got %0d, required 0", rd_count); end
    if (wr_count !== 32'd0)    begin n_fail++; $display("FAIL rst_wr_count: got %0d, required 0", wr_count); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_read_basic();
    bd_write(10'd5, {32{16'h1711}});
    tick();
    issue_rd(42'd5, 16'hA5, {32{16'h1711}});
    tick();
    wait_drain("read_basic");
    n_checks++;
    if (rd_count !== 32'(exp_rd)) begin n_fail++; $display("FAIL read_basic_rd_count: got %0d, required %0d", rd_count, exp_rd); end
  endtask

  task automatic test_write_then_read();
    issue_wr(42'd9, 512'h2A, 16'h3);
    tick();
    issue_rd(42'd9, 16'h9, 512'h2A);
    tick();
    wait_drain("wr_rd");
    n_checks++;
    if (wr_count !== 32'(exp_wr)) begin n_fail++; $display("FAIL wr_rd_wr_count: got %0d, required %0d", wr_count, exp_wr); end
  endtask

  task automatic test_same_cycle();
    bd_write(10'd2, 512'h11);
    tick();
    issue_wr(42'd2, 512'hFF, 16'h21);
    issue_rd(42'd2, 16'h22, 512'h11);
    tick();
    bd_rd_en = 1'b1; bd_addr = 10'd2;
    tick();
    n_checks++;
    if (bd_rd_data !== 512'hFF) begin n_fail++; $display("FAIL same_bd_rd_new: got %h, required ff", bd_rd_data); end
    bd_write(10'd3, 512'h33);
    tick();
    issue_wr(42'd3, 512'hAA, 16'h23);
    bd_write(10'd3, 512'hBB);
    bd_rd_en = 1'b1;
    tick();
    n_checks++;
    if (bd_rd_data !== 512'h33) begin n_fail++; $display("FAIL bd_rd_collision: got %h, required 33", bd_rd_data); end
    bd_rd_en = 1'b1; bd_addr = 10'd3;
    issue_rd(42'd3, 16'h24, 512'hBB);
    tick();
    n_checks++;
    if (bd_rd_data !== 512'hBB) begin n_fail++; $display("FAIL bd_wins: got %h, required bb", bd_rd_data); end
    wait_drain("same_cycle");
  endtask

  task automatic test_back_to_back();
    logic exp_alm;
    for (int i = 0; i < 4; i++) begin
      bd_write(10'(10 + i), pat(i));
      tick();
    end
    for (int k = 0; k < 9; k++) begin
      if (k < 4) issue_rd(42'(10 + k), 16'(k), pat(k));
      exp_alm = (k >= 3 && k <= 5);
      n_checks++;
      if (c0_alm_full !== exp_alm) begin
        n_fail++;
        $display("FAIL b2b_alm_full_k%0d: got %b, required %b", k, c0_alm_full, exp_alm);
      end
      tick();
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_inflight();
    int seen;
    bd_write(10'd20, pat(20));
    tick();
    c0_req_valid = 1'b1; c0_req_addr = 42'd20; c0_req_mdata = 16'h51;
    tick();
    c0_req_valid = 1'b1; c0_req_addr = 42'd20; c0_req_mdata = 16'h52;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_rd = 0;
    exp_wr = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (c0_rsp_valid) seen++;
      tick();
    end
    n_checks += 4;
    if (seen != 0)          begin n_fail++; $display("FAIL rst_drop: got %0d responses, required 0", seen); end
    if (rd_count !== 32'd0) begin n_fail++; $display("FAIL rst_drop_rd_count: got %0d, required 0", rd_count); end
    bd_rd_en = 1'b1; bd_addr = 10'd20;
    tick();
    if (bd_rd_data !== pat(20)) begin n_fail++; $display("FAIL rst_mem_kept20: got %h, required %h", bd_rd_data, pat(20)); end
    bd_rd_en = 1'b1; bd_addr = 10'd5;
    tick();
    if (bd_rd_data !== {32{16'h1711}}) begin n_fail++; $display("FAIL rst_mem_kept5: got %h, required %h", bd_rd_data, {32{16'h1711}}); end
  endtask

  task automatic test_upper_addr();
    bd_write(10'd0, pat(99));
    tick();
    issue_rd(42'h400, 16'h31, 512'h0);
    issue_wr(42'h400, pat(7), 16'h32);
    tick();
    wait_drain("upper");
    bd_rd_en = 1'b1; bd_addr = 10'd0;
    tick();
    n_checks += 3;
    if (bd_rd_data !== pat(99)) begin n_fail++; $display("FAIL upper_line0: got %h, required %h", bd_rd_data, pat(99)); end
    if (rd_count !== 32'd1)     begin n_fail++; $display("FAIL upper_rd_count: got %0d, required 1", rd_count); end
    if (wr_count !== 32'd1)     begin n_fail++; $display("FAIL upper_wr_count: got %0d, required 1", wr_count); end
  endtask

  initial begin
    reset_n = 1'b0;
    c0_req_valid = 1'b0; c0_req_addr = '0; c0_req_mdata = '0;
    c1_req_valid = 1'b0; c1_req_addr = '0; c1_req_data = '0; c1_req_mdata = '0;
    bd_wr_en = 1'b0; bd_rd_en = 1'b0; bd_addr = '0; bd_wr_data = '0;
    test_reset();
    test_read_basic();
    test_write_then_read();
    test_same_cycle();
    test_back_to_back();
    test_reset_inflight();
    test_upper_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccip_host_mem_responder.md
Name: ccip_host_mem_responder

Overview:
- Host-side responder for the CCI-P request/response channels used by our AFUs.
- Accepts single-line c0 memory read requests and c1 memory write requests, services them from an internal line-addressed memory, and returns fixed-latency c0 read responses and c1 write responses carrying the request mdata.
- Serves as the FIU/host end in unit benches and loopback builds; a backdoor port lets the bench preload and check memory.

Parameters:
- ADDR_W, 42, width of the cache-line address.
- DATA_W, 512, line width in bits.
- MDATA_W, 16, request tag width, returned unchanged in the response.
- DEPTH_LOG2, 10, the memory holds 2**DEPTH_LOG2 lines.
- RD_LATENCY, 4, cycles from read-request acceptance to c0_rsp_valid; legal range 1..16.
- WR_LATENCY, 2, cycles from write-request acceptance to c1_rsp_valid; legal range 1..16.
- ALMFULL_THRESH, 3, in-flight count per channel at which that channel's almost-full output asserts.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- c0_req_valid  in  1  read request strobe
- c0_req_addr  in  ADDR_W  read line address
- c0_req_mdata  in  MDATA_W  read tag
- c1_req_valid  in  1  write request strobe
- c1_req_addr  in  ADDR_W  write line address
- c1_req_data  in  DATA_W  write data
- c1_req_mdata  in  MDATA_W  write tag
- c0_alm_full  out  1  read channel almost full
- c1_alm_full  out  1  write channel almost full
- c0_rsp_valid  out  1  read response strobe
- c0_rsp_data  out  DATA_W  read data
- c0_rsp_mdata  out  MDATA_W  read tag echo
- c1_rsp_valid  out  1  write response strobe
- c1_rsp_mdata  out  MDATA_W  write tag echo
- bd_wr_en  in  1  backdoor write
- bd_rd_en  in  1  backdoor read
- bd_addr  in  DEPTH_LOG2  backdoor line index
- bd_wr_data  in  DATA_W  backdoor write data
- bd_rd_data  out  DATA_W  backdoor read data, valid 1 cycle after bd_rd_en
- rd_count  out  32  accepted reads, wraps modulo 2**32
- wr_count  out  32  accepted writes, wraps modulo 2**32

Behaviour:
- Reset: all *_valid, alm_full, rd_count, wr_count, bd_rd_data, rsp_data, and rsp_mdata are 0. Both latency pipelines are flushed; requests in flight at reset are dropped with no response. Memory contents are not reset.
- Requests are always accepted. There is no ready signal, and the requester honours alm_full, but requests arriving while alm_full is high are still accepted.
- Read: memory is sampled in the acceptance cycle. c0_rsp_valid, data, and mdata appear exactly RD_LATENCY cycles later. One response is produced per request, in order, with no response backpressure.
- Write: memory is updated at the clock edge ending the acceptance cycle. c1_rsp_valid and mdata appear WR_LATENCY cycles later.
- Address decode: the line index is addr[DEPTH_LOG2-1:0]. If any upper address bit is set:
  - a read returns all-zero data;
  - a write is discarded;
  - a response is still generated and the count still increments.
- Ordering:
  - A write and a read to the same line in the same cycle: the read returns the old data.
  - A read in any later cycle sees the new data.
- Backdoor:
  - bd_wr_en commits at the same edge as c1.
  - If bd_wr_en and c1 write the same line in the same cycle, backdoor data wins.
  - bd_rd_data is registered with 1-cycle latency and returns pre-write data on a same-cycle collision.
- In-flight count per channel: +1 on accept, −1 on response, and unchanged if both happen in one cycle. alm_full is registered: high the cycle after in-flight >= ALMFULL_THRESH, low the cycle after it drops below.
- Counters increment on each accepted request.

Test Plan:
- Backdoor-write line 5 = 0x...1711; c0 read addr 5, mdata 0xA5 at cycle T -> c0_rsp_valid only at T+4, data 0x...1711, mdata 0xA5; rd_count = 1.
- c1 write addr 9, data 0x2A, mdata 0x3 at T; c0 read addr 9 at T+1 -> c1_rsp_valid at T+2 with mdata 0x3; read response at T+5 with data 0x2A.
- Same-cycle c1 write addr 2 = 0xFF and c0 read addr 2 (old value 0x11) -> read response data 0x11; backdoor read of addr 2 one cycle later returns 0xFF.
- Reads on 4 consecutive cycles, mdata 0..3 -> c0_alm_full high in the cycle after the 3rd accept; responses arrive in order with mdata 0,1,2,3 on consecutive cycles; c0_alm_full low again after the drain.
- Read addr 2**10 (upper bit set) and write to the same addr -> read data 0, memory line 0 unchanged, both responses present, rd_count = 1 and wr_count = 1.
- Issue 2 reads, then assert reset_n = 0 for 1 cycle -> no c0_rsp_valid ever appears for them; counts = 0; memory contents preserved (check via backdoor).
